// File: rtl/rs_dispatch_arbiter.sv
// rs_dispatch_arbiter
// Picks one ready reservation station per cycle and loads its operation into
// a one-entry output register. The execute unit drains that register through a
// valid/ready handshake.
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   mispredicted      flush: empties the output register, blocks capture
//   rob_head          ROB head tag; oldest-first age is measured from it
//   rs_*              per-station bank view, station 0 in the LSBs
//   consumed_bus      one-hot clear of the station captured at this edge
//   fu_valid/fu_ready output register handshake
//   fu_*              dispatched fields; fu_src is the source station index
//   disp_count        wrapping dispatch counter

// Per-station eligibility and ROB age relative to the head.
module rs_dispatch_lane #(
    parameter int ROB_W = 4
) (
    input  logic             busy,
    input  logic             valid_ops,
    input  logic [ROB_W-1:0] rob,
    input  logic [ROB_W-1:0] rob_head,
    output logic             elig,
    output logic [ROB_W-1:0] age
);
    // Tag 0 is reserved as "no ROB entry" and is never dispatched.
    assign elig = busy & valid_ops & (rob != '0);
    // Modular difference: tags behind the head by wraparound come out large,
    // which makes them the youngest.
    assign age  = rob - rob_head;
endmodule

module rs_dispatch_arbiter #(
    parameter int NUM_RS  = 4,
    parameter int ROB_W   = 4,
    parameter int OP_W    = 4,
    parameter int XLEN    = 32,
    parameter int RR_MODE = 0,
    localparam int IDX_W  = (NUM_RS > 1) ? $clog2(NUM_RS) : 1
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     mispredicted,
    input  logic [ROB_W-1:0]         rob_head,
    input  logic [NUM_RS-1:0]        rs_busy,
    input  logic [NUM_RS-1:0]        rs_valid_ops,
    input  logic [NUM_RS*ROB_W-1:0]  rs_rob,
    input  logic [NUM_RS*OP_W-1:0]   rs_op,
    input  logic [NUM_RS*XLEN-1:0]   rs_v1,
    input  logic [NUM_RS*XLEN-1:0]   rs_v2,
    input  logic [NUM_RS*2-1:0]      rs_branch_type,
    input  logic [NUM_RS-1:0]        rs_load,
    output logic [NUM_RS-1:0]        consumed_bus,
    output logic                     fu_valid,
    input  logic                     fu_ready,
    output logic [ROB_W-1:0]         fu_rob,
    output logic [OP_W-1:0]          fu_op,
    output logic [XLEN-1:0]          fu_v1,
    output logic [XLEN-1:0]          fu_v2,
    output logic [1:0]               fu_branch_type,
    output logic                     fu_load,
    output logic [IDX_W-1:0]         fu_src,
    output logic [15:0]              disp_count
);

    typedef struct packed {
        logic [ROB_W-1:0] rob;
        logic [OP_W-1:0]  op;
        logic [XLEN-1:0]  v1;
        logic [XLEN-1:0]  v2;
        logic [1:0]       br;
        logic             load;
    } disp_t;

    disp_t              st  [NUM_RS];
    logic [ROB_W-1:0]   age [NUM_RS];
    logic [NUM_RS-1:0]  elig;
    disp_t              fu_q;
    logic [IDX_W-1:0]   rr_ptr;
    logic [IDX_W-1:0]   rr_next;
    logic [IDX_W-1:0]   rr_idx;
    logic [IDX_W-1:0]   win;
    logic [ROB_W-1:0]   best_age;
    logic               found;
    logic               cap;

    for (genvar g = 0; g < NUM_RS; g++) begin : g_rs
        rs_dispatch_lane #(.ROB_W(ROB_W)) u_lane (
            .busy      (rs_busy[g]),
            .valid_ops (rs_valid_ops[g]),
            .rob       (rs_rob[g*ROB_W +: ROB_W]),
            .rob_head  (rob_head),
            .elig      (elig[g]),
            .age       (age[g])
        );
        assign st[g] = '{rob:  rs_rob[g*ROB_W +: ROB_W],
                         op:   rs_op[g*OP_W +: OP_W],
                         v1:   rs_v1[g*XLEN +: XLEN],
                         v2:   rs_v2[g*XLEN +: XLEN],
                         br:   rs_branch_type[g*2 +: 2],
                         load: rs_load[g]};
    end

    // Winner select. Oldest-first uses a strict '<' so the lowest index keeps
    // ties; round-robin scans upward from rr_ptr with wrap.
    always_comb begin
        found    = 1'b0;
        win      = '0;
        best_age = '1;
        rr_idx   = '0;
        if (RR_MODE == 0) begin
            for (int i = 0; i < NUM_RS; i++) begin
                if (elig[i] && (!found || age[i] < best_age)) begin
                    found    = 1'b1;
                    win      = IDX_W'(i);
                    best_age = age[i];
                end
            end
        end else begin
            for (int k = 0; k < NUM_RS; k++) begin
                rr_idx = IDX_W'((int'(rr_ptr) + k) % NUM_RS);
                if (!found && elig[rr_idx]) begin
                    found = 1'b1;
                    win   = rr_idx;
                end
            end
        end
    end

    // Capture only when the register is free or draining this same edge.
    assign cap          = found & ~mispredicted & ~reset & (~fu_valid | fu_ready);
    assign consumed_bus = cap ? (NUM_RS'(1) << win) : '0;
    assign rr_next      = (win == IDX_W'(NUM_RS - 1)) ? '0 : win + IDX_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            fu_valid   <= 1'b0;
            fu_q       <= '0;
            fu_src     <= '0;
            rr_ptr     <= '0;
            disp_count <= '0;
        end else if (mispredicted) begin
            fu_valid <= 1'b0;
            fu_q     <= '0;
            fu_src   <= '0;
        end else if (cap) begin
            fu_valid   <= 1'b1;
            fu_q       <= st[win];
            fu_src     <= win;
            rr_ptr     <= rr_next;
            disp_count <= disp_count + 16'd1;
        end else if (fu_valid && fu_ready) begin
            fu_valid <= 1'b0;
        end
    end

    assign fu_rob         = fu_q.rob;
    assign fu_op          = fu_q.op;
    assign fu_v1          = fu_q.v1;
    assign fu_v2          = fu_q.v2;
    assign fu_branch_type = fu_q.br;
    assign fu_load        = fu_q.load;

endmodule
